// File: rtl/basket_text_scheduler.sv
// Round-robin line-update scheduler for the 12x9 on-screen text buffer; commits writes only in vertical blanking.
// Optional LINE_ERR_EN adds a sticky line_err flag for acked out-of-range line requests.
module basket_text_scheduler #(
  parameter int                N_REQ        = 2,
  parameter int                LINES        = 12,
  parameter int                CHARS        = 9,
  parameter int                CHAR_W       = 7,
  parameter int                VBLANK_START = 480,
  parameter logic [CHAR_W-1:0] BLANK_CHAR   = 7'h20
) (
  input  logic                             CLK,
  input  logic                             rst_n,
  input  logic [9:0]                       V_counter,
  input  logic [N_REQ-1:0]                 req,
  input  logic [4*N_REQ-1:0]               req_line,
  input  logic [CHARS*CHAR_W*N_REQ-1:0]    req_text,
  output logic [N_REQ-1:0]                 ack,
  input  logic                             clear_all,
  output logic                             busy,
`ifdef LINE_ERR_EN
  output logic                             line_err,
`endif
  output logic [LINES*CHARS*CHAR_W-1:0]    words
);

  localparam int LINE_BITS = CHARS * CHAR_W;
  localparam int PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [LINE_BITS-1:0] BLANK_LINE = {CHARS{BLANK_CHAR}};
  localparam logic [3:0] LAST_LINE = 4'(LINES - 1);
  localparam logic [9:0] VB_START  = 10'(VBLANK_START);

  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

  state_t                 state, state_nxt;
  logic                   vblank_q;
  logic [PTR_W-1:0]       rr_ptr, rr_nxt, sel, sel_nxt;
  logic                   clear_pend, clear_pend_nxt;
  logic [3:0]             line_idx, line_idx_nxt;
  logic                   wr_en;
  logic [3:0]             wr_line;
  logic [LINE_BITS-1:0]   wr_data;
  logic [3:0]             sel_line;
  logic [LINE_BITS-1:0]   sel_text;
  logic                   sel_req;

  assign sel_line = req_line[int'(sel)*4 +: 4];
  assign sel_text = req_text[int'(sel)*LINE_BITS +: LINE_BITS];
  assign sel_req  = req[sel];
  assign busy     = (state != IDLE) | clear_pend;

  // First active requester at or after ptr, wrapping around.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] pick;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && r[idx]) begin
        pick  = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    rr_nxt         = rr_ptr;
    clear_pend_nxt = clear_pend | clear_all;
    line_idx_nxt   = line_idx;
    wr_en          = 1'b0;
    wr_line        = sel_line;
    wr_data        = sel_text;
    ack            = '0;
    case (state)
      IDLE: begin
        if (clear_all || clear_pend) begin
          state_nxt    = CLEAR;
          line_idx_nxt = 4'd0;
        end else if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = rr_pick(req, rr_ptr);
        end
      end
      GRANT: begin
        if (!sel_req) begin
          state_nxt = IDLE;
        end else if (vblank_q) begin
          ack[sel]  = 1'b1;
          wr_en     = (sel_line <= LAST_LINE);
          rr_nxt    = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        // A fresh clear_all restarts the sweep from line 0.
        if (clear_all) begin
          line_idx_nxt = 4'd0;
        end else if (vblank_q) begin
          wr_en   = 1'b1;
          wr_line = line_idx;
          wr_data = BLANK_LINE;
          if (line_idx == LAST_LINE) begin
            state_nxt      = IDLE;
            clear_pend_nxt = 1'b0;
          end else begin
            line_idx_nxt = line_idx + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LINE_ERR_EN
  logic oor_ack, clear_done;
  assign oor_ack    = (state == GRANT) && sel_req && vblank_q && (sel_line > LAST_LINE);
  assign clear_done = (state == CLEAR) && !clear_all && vblank_q && (line_idx == LAST_LINE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)          line_err <= 1'b0;
    else if (oor_ack)    line_err <= 1'b1;
    else if (clear_done) line_err <= 1'b0;
  end
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vblank_q   <= 1'b0;
      rr_ptr     <= '0;
      sel        <= '0;
      clear_pend <= 1'b0;
      line_idx   <= 4'd0;
      words      <= {LINES{BLANK_LINE}};
    end else begin
      state      <= state_nxt;
      vblank_q   <= (V_counter >= VB_START);
      rr_ptr     <= rr_nxt;
      sel        <= sel_nxt;
      clear_pend <= clear_pend_nxt;
      line_idx   <= line_idx_nxt;
      // Line 0 occupies the most significant slice of the buffer.
      for (int l = 0; l < LINES; l++) begin
        if (wr_en && (wr_line == 4'(l)))
          words[(LINES-1-l)*LINE_BITS +: LINE_BITS] <= wr_data;
      end
    end
  end

endmodule

// File: doc/basket_text_scheduler.md
Name: basket_text_scheduler

Overview:
- Owns the 12-line x 9-character text buffer (`words`, 756 bits) that the on-screen basket/text renderer reads.
- Arbitrates line-update requests from several producers (keypad entry, price calculator, ...) with round-robin priority.
- Commits every buffer change only during vertical blanking, so the renderer never shows a half-updated frame.
- Also sequences a multi-frame-safe "clear all" command.

Parameters:
- N_REQ, 2, number of requesters.
- LINES, 12, number of text lines in the buffer.
- CHARS, 9, characters per line.
- CHAR_W, 7, bits per character code (font ROM index).
- VBLANK_START, 480, first V_counter value treated as blanking; blanking lasts while V_counter >= VBLANK_START.
- BLANK_CHAR, 7'h20, character code written by reset and by clear.

Ports:
- CLK  in  1  system/pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- V_counter  in  10  vertical position from the VGA timing generator.
- req  in  N_REQ  per-requester write request; level, held until ack.
- req_line  in  4*N_REQ  per-requester target line index; requester i uses bits [4i+3:4i].
- req_text  in  CHARS*CHAR_W*N_REQ  per-requester 63-bit line text; char 0 in the MSBs.
- ack  out  N_REQ  one-cycle pulse; the request was consumed.
- clear_all  in  1  one-cycle pulse; blank the whole buffer.
- busy  out  1  high while a clear is in progress or a grant is pending.
- words  out  LINES*CHARS*CHAR_W  text buffer; line 0 = bits [755:693], line 11 = bits [62:0].

Behaviour:
- Reset (async, rst_n=0):
  - words = all BLANK_CHAR; ack=0; busy=0.
  - Round-robin pointer = requester 0; clear-pending = 0; state = IDLE.
  - Takes effect immediately and aborts any clear or write in progress. No partial line may remain.
- V_counter is registered once (vblank_q). All blanking decisions use vblank_q, giving one cycle of latency.
- States and transitions:
  - IDLE:
    - clear_all or clear-pending -> CLEAR with line_idx=0.
    - Else any req -> GRANT: pick the first requester at or after the RR pointer (wrapping).
  - GRANT: hold the selected index.
    - If vblank_q=1: write req_text[sel] into line req_line[sel], pulse ack[sel] in the same cycle, advance the RR pointer to sel+1 (mod N_REQ), return to IDLE.
    - If vblank_q=0: wait.
  - CLEAR: each cycle with vblank_q=1, write BLANK_CHAR to line line_idx and increment line_idx.
    - After line LINES-1, go to IDLE and clear clear-pending.
    - If blanking ends mid-clear, pause and resume at the same line_idx in the next blank.
- Throughput: at most one line write per cycle. Successive grants are separated by one IDLE cycle.
- clear_all arriving in any state sets clear-pending; it is serviced on the next return to IDLE.
  - clear_all during CLEAR restarts line_idx at 0.
  - A clear never preempts a GRANT already issued.
- Out-of-range line (req_line >= LINES): ack is pulsed normally (in blanking, as for a valid write); no buffer bit changes.
- req deasserted while granted: no write, no ack, return to IDLE, RR pointer unchanged.
- busy = (state != IDLE) | clear-pending.
- words changes only on write cycles. Outside blanking it is guaranteed stable.

Optional Feature:
- Macro: LINE_ERR_EN.
- Defined:
  - Adds output `line_err` (1 bit), sticky-set on any ack issued for an out-of-range req_line.
  - Cleared only by reset or by completion of a clear_all sequence.
- Undefined: the port does not exist; out-of-range requests are silently acked.

Test Plan:
1. Reset, then hold V_counter=100 -> words = 108 copies of 7'h20; busy=0; ack=0.
2. req[0]=1, line 3, text "APPLE    " at V_counter=200; then ramp V_counter to 480 -> no write before blanking; ack[0] pulses exactly one cycle after V_counter reaches 480; only words[566:504] changes.
3. req[0] and req[1] both held, blanking active -> grants alternate 0,1,0,1 over four requests; no requester is acked twice in a row while the other is waiting.
4. clear_all with V_counter=480 for only 5 cycles, then 0, then 480 again -> lines 0-3 or 0-4 blank first (per the registered-blanking latency), then the rest complete in the next blank; busy stays high throughout.
5. req_line=13 in blanking -> ack pulses, words unchanged; with LINE_ERR_EN, line_err=1 until the next completed clear.
6. rst_n low mid-CLEAR -> immediate all-blank words, state IDLE, busy=0 the same cycle rst_n falls.
